// File: rtl/mlp_infer_ctrl.sv
// Runs one inference of a 16-input, N_HID-hidden, 2-output MLP over a single MAC and an external 1-cycle ROM.
// Latency: done pulses 165 cycles after the start-sampling edge at defaults; no backpressure, start ignored while running.
module mlp_infer_ctrl #(
    parameter int N_IN     = 16,
    parameter int N_HID    = 8,
    parameter int OUT_BASE = 136
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [N_IN-1:0] pattern,
    output logic            rom_en,
    output logic [7:0]      rom_addr,
    input  logic [7:0]      rom_data,
    output logic            busy,
    output logic            done,
    output logic [1:0]      result,
    output logic [19:0]     score_o,
    output logic [19:0]     score_x
);

    localparam int IDX_W = $clog2(N_IN + 1);
    localparam int PAT_W = $clog2(N_IN);
    localparam int NRN_W = $clog2(N_HID);
    localparam logic [IDX_W-1:0] LAST_IN  = IDX_W'(N_IN);
    localparam logic [IDX_W-1:0] LAST_HID = IDX_W'(N_HID);
    localparam logic [NRN_W-1:0] LAST_NRN = NRN_W'(N_HID - 1);
    localparam logic [NRN_W-1:0] NRN_ONE  = NRN_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        HID,
        HID_DRAIN,
        OUT,
        OUT_DRAIN,
        DECIDE
    } state_t;

    state_t            state;
    logic [NRN_W-1:0]  nrn;
    logic [IDX_W-1:0]  idx;
    logic [N_IN-1:0]   pat;

    // Tag of the read issued last cycle; travels alongside the returning rom_data.
    logic              d_vld;
    logic              d_out;
    logic [NRN_W-1:0]  d_nrn;
    logic [IDX_W-1:0]  d_idx;
    logic              d_bias;

    logic signed [19:0] acc;
    logic signed [19:0] term;
    logic signed [19:0] acc_sum;
    logic signed [16:0] w_ext17;
    logic signed [16:0] h_ext17;
    logic signed [16:0] prod;
    logic [7:0]         hid [N_HID];
    logic [7:0]         hid_rd;

    function automatic logic [7:0] relu8(input logic signed [19:0] v);
        if (v < 20'sd0)
            return 8'd0;
        else if (v > 20'sd255)
            return 8'hFF;
        else
            return v[7:0];
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            nrn      <= '0;
            idx      <= '0;
            pat      <= '0;
            rom_en   <= 1'b0;
            rom_addr <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= 2'b00;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (start) begin
                        pat      <= pattern;
                        nrn      <= '0;
                        idx      <= '0;
                        rom_en   <= 1'b1;
                        rom_addr <= '0;
                        state    <= HID;
                    end
                end
                HID: begin
                    busy <= 1'b1;
                    if (idx == LAST_IN) begin
                        rom_en <= 1'b0;
                        state  <= HID_DRAIN;
                    end else begin
                        idx      <= idx + IDX_W'(1);
                        rom_addr <= rom_addr + 8'd1;
                    end
                end
                HID_DRAIN: begin
                    busy   <= 1'b1;
                    idx    <= '0;
                    rom_en <= 1'b1;
                    if (nrn == LAST_NRN) begin
                        nrn      <= '0;
                        rom_addr <= 8'(OUT_BASE);
                        state    <= OUT;
                    end else begin
                        nrn      <= nrn + NRN_W'(1);
                        rom_addr <= rom_addr + 8'd1;
                        state    <= HID;
                    end
                end
                OUT: begin
                    busy <= 1'b1;
                    if (idx == LAST_HID) begin
                        rom_en <= 1'b0;
                        state  <= OUT_DRAIN;
                    end else begin
                        idx      <= idx + IDX_W'(1);
                        rom_addr <= rom_addr + 8'd1;
                    end
                end
                OUT_DRAIN: begin
                    busy <= 1'b1;
                    idx  <= '0;
                    if (nrn == NRN_ONE) begin
                        state <= DECIDE;
                    end else begin
                        nrn      <= NRN_ONE;
                        rom_en   <= 1'b1;
                        rom_addr <= rom_addr + 8'd1;
                        state    <= OUT;
                    end
                end
                DECIDE: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    // Ties go to O; a class only wins with a strictly positive score.
                    if ($signed(score_o) > 20'sd0 && $signed(score_o) >= $signed(score_x))
                        result <= 2'b01;
                    else if ($signed(score_x) > 20'sd0 && $signed(score_x) > $signed(score_o))
                        result <= 2'b10;
                    else
                        result <= 2'b00;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        hid_rd  = hid[d_idx[NRN_W-1:0]];
        d_bias  = d_out ? (d_idx == LAST_HID) : (d_idx == LAST_IN);
        w_ext17 = {{9{rom_data[7]}}, rom_data};
        h_ext17 = {9'b0, hid_rd};
        prod    = w_ext17 * h_ext17;
        term    = '0;
        if (d_bias)
            term = {{12{rom_data[7]}}, rom_data};
        else if (d_out)
            term = {{3{prod[16]}}, prod};
        else if (pat[d_idx[PAT_W-1:0]])
            term = {{12{rom_data[7]}}, rom_data};
        acc_sum = acc + term;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d_vld   <= 1'b0;
            d_out   <= 1'b0;
            d_nrn   <= '0;
            d_idx   <= '0;
            acc     <= '0;
            score_o <= '0;
            score_x <= '0;
            for (int j = 0; j < N_HID; j++)
                hid[j] <= '0;
        end else begin
            d_vld <= rom_en;
            d_out <= (state == OUT);
            d_nrn <= nrn;
            d_idx <= idx;
            if (state == IDLE && start) begin
                acc <= '0;
            end else if (d_vld) begin
                if (d_bias) begin
                    acc <= '0;
                    if (!d_out)
                        hid[d_nrn] <= relu8(acc_sum);
                    else if (d_nrn[0])
                        score_x <= acc_sum;
                    else
                        score_o <= acc_sum;
                end else begin
                    acc <= acc_sum;
                end
            end
        end
    end

endmodule

// File: tb/tb_mlp_infer_ctrl.sv
// Drives mlp_infer_ctrl with a 1-cycle-latency ROM and checks every output every cycle
// against a cycle-indexed arithmetic model of the inference.
module tb_mlp_infer_ctrl;

    localparam int N_IN     = 16;
    localparam int N_HID    = 8;
    localparam int OUT_BASE = N_HID * (N_IN + 1);
    localparam int HCYC     = N_IN + 2;
    localparam int OCYC     = N_HID + 2;
    localparam int HEND     = N_HID * HCYC;
    localparam int LAT      = HEND + 2 * OCYC + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] pattern;
    logic        rom_en;
    logic [7:0]  rom_addr;
    logic [7:0]  rom_data;
    logic        busy;
    logic        done;
    logic [1:0]  result;
    logic [19:0] score_o;
    logic [19:0] score_x;

    logic [7:0]  rom [256];

    int          checks = 0;
    int          errors = 0;
    int          k = -1;
    bit          chk_en = 1'b0;
    int          m_so;
    int          m_sx;
    logic [1:0]  m_res;
    logic [19:0] exp_so = '0;
    logic [19:0] exp_sx = '0;
    logic [1:0]  exp_res = '0;

    always #5 clk = ~clk;

    mlp_infer_ctrl #(.N_IN(N_IN), .N_HID(N_HID), .OUT_BASE(OUT_BASE)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .pattern  (pattern),
        .rom_en   (rom_en),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .score_o  (score_o),
        .score_x  (score_x)
    );

    // Synchronous ROM; returns noise when not enabled so stray accumulation shows up.
    always @(posedge clk)
        rom_data <= rom_en ? rom[rom_addr] : 8'($urandom);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model(input logic [15:0] p, output int so, output int sx,
                                  output logic [1:0] res);
        int h_act [N_HID];
        int acc;
        for (int h = 0; h < N_HID; h++) begin
            acc = 0;
            for (int i = 0; i < N_IN; i++)
                if (p[i]) acc += $signed(rom[h * (N_IN + 1) + i]);
            acc += $signed(rom[h * (N_IN + 1) + N_IN]);
            h_act[h] = (acc < 0) ? 0 : ((acc > 255) ? 255 : acc);
        end
        so = 0;
        sx = 0;
        for (int j = 0; j < N_HID; j++) begin
            so += $signed(rom[OUT_BASE + j]) * h_act[j];
            sx += $signed(rom[OUT_BASE + N_HID + 1 + j]) * h_act[j];
        end
        so += $signed(rom[OUT_BASE + N_HID]);
        sx += $signed(rom[OUT_BASE + 2 * N_HID + 1]);
        if (so > 0 && so >= sx)
            res = 2'b01;
        else if (sx > 0 && sx > so)
            res = 2'b10;
        else
            res = 2'b00;
    endfunction

    function automatic logic exp_en(input int kk);
        if (kk < 0) return 1'b0;
        if (kk < HEND) return (kk % HCYC) < (N_IN + 1);
        if (kk < HEND + 2 * OCYC) return ((kk - HEND) % OCYC) < (N_HID + 1);
        return 1'b0;
    endfunction

    function automatic int exp_addr(input int kk);
        if (kk < HEND) return (kk / HCYC) * (N_IN + 1) + kk % HCYC;
        return OUT_BASE + ((kk - HEND) / OCYC) * (N_HID + 1) + (kk - HEND) % OCYC;
    endfunction

    // k = index of the cycle following the edge that accepted start, -1 when idle.
    always @(posedge clk) begin
        if (rst) begin
            k       = -1;
            exp_so  = '0;
            exp_sx  = '0;
            exp_res = 2'b00;
        end else begin
            if (k >= 0) k++;
            if (k > LAT) k = -1;
            if (k < 0 && start) begin
                k = 0;
                model(pattern, m_so, m_sx, m_res);
            end
            if (k == HEND + OCYC)     exp_so  = 20'(m_so);
            if (k == HEND + 2 * OCYC) exp_sx  = 20'(m_sx);
            if (k == LAT)             exp_res = m_res;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", busy, (k >= 1 && k <= LAT - 1));
            chk("done", done, (k == LAT));
            chk("rom_en", rom_en, exp_en(k));
            if (exp_en(k)) chk("rom_addr", rom_addr, exp_addr(k));
            chk("result", result, exp_res);
            chk("score_o", score_o, exp_so);
            chk("score_x", score_x, exp_sx);
        end
    end

    task automatic clear_rom();
        for (int a = 0; a < 256; a++) rom[a] = 8'h00;
    endtask

    task automatic fill_rand(input int span);
        for (int a = 0; a < 256; a++)
            rom[a] = 8'($urandom_range(0, 2 * span) - span);
    endtask

    task automatic run(input logic [15:0] p, input int repulse_at, input logic [15:0] p2);
        int n;
        n = 0;
        pattern = p;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        pattern = 16'($urandom);
        while (done !== 1'b1 && n < 2 * LAT) begin
            @(posedge clk); #1;
            n++;
            if (n == repulse_at) begin
                start = 1'b1;
                pattern = p2;
            end else begin
                start = 1'b0;
            end
        end
        chk("latency", n, LAT);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        start = 1'b0;
        pattern = '0;
        clear_rom();
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        rst = 1'b0;
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_result", result, 0);
        chk("rst_score_o", score_o, 0);
        repeat (2) @(posedge clk);
        #1;

        // All-zero ROM.
        run(16'hF99F, -1, 16'h0);
        chk("zero_result", result, 2'b00);
        chk("zero_score_o", score_o, 0);
        chk("zero_score_x", score_x, 0);

        // Ring detector on hidden 0 feeding output O.
        clear_rom();
        for (int i = 0; i < N_IN; i++) begin
            logic [15:0] ring;
            ring = 16'hF99F;
            rom[i] = ring[i] ? 8'd10 : 8'hF6;
        end
        rom[OUT_BASE] = 8'd1;
        run(16'hF99F, -1, 16'h0);
        chk("ring_model_so", m_so, 120);
        chk("ring_score_o", score_o, 120);
        chk("ring_score_x", score_x, 0);
        chk("ring_result", result, 2'b01);

        // Saturating hidden neuron feeding output X.
        clear_rom();
        for (int i = 0; i <= N_IN; i++) rom[i] = 8'd127;
        rom[OUT_BASE + N_HID + 1] = 8'd127;
        run(16'hFFFF, -1, 16'h0);
        chk("sat_model_sx", m_sx, 32385);
        chk("sat_score_x", score_x, 32385);
        chk("sat_result", result, 2'b10);

        // Bias-only tie, then both negative.
        clear_rom();
        rom[OUT_BASE + N_HID] = 8'd50;
        rom[OUT_BASE + 2 * N_HID + 1] = 8'd50;
        run(16'h0F0F, -1, 16'h0);
        chk("tie_result", result, 2'b01);
        chk("tie_score_x", score_x, 50);
        rom[OUT_BASE + N_HID] = 8'hFB;
        rom[OUT_BASE + 2 * N_HID + 1] = 8'hFB;
        run(16'h0F0F, -1, 16'h0);
        chk("neg_result", result, 2'b00);
        chk("neg_score_o", score_o, 20'hFFFFB);

        // Restart attempt mid-run is ignored.
        fill_rand(30);
        run(16'h5A5A, 40, 16'hA5A5);
        run(16'h0001, 60, 16'hFFFF);

        // Randomized runs.
        for (int r = 0; r < 5; r++) begin
            fill_rand((r % 2 == 0) ? 30 : 127);
            run(16'($urandom), -1, 16'h0);
        end

        // start held high: back-to-back inferences.
        fill_rand(25);
        pattern = 16'hA5C3;
        start = 1'b1;
        @(posedge clk); #1;
        pattern = 16'h3C3C;
        n = 0;
        while (done !== 1'b1 && n < 2 * LAT) begin
            @(posedge clk); #1;
            n++;
        end
        chk("b2b_latency1", n, LAT);
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b_restart_en", rom_en, 1'b1);
        n = 0;
        while (done !== 1'b1 && n < 2 * LAT) begin
            @(posedge clk); #1;
            n++;
        end
        chk("b2b_latency2", n - 1, LAT - 1);
        @(posedge clk); #1;

        // Reset in the middle of a run.
        fill_rand(30);
        pattern = 16'h1234;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (80) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_rom_en", rom_en, 1'b0);
        chk("mid_rst_rom_addr", rom_addr, 0);
        chk("mid_rst_result", result, 2'b00);
        chk("mid_rst_score_o", score_o, 0);
        chk("mid_rst_score_x", score_x, 0);
        repeat (200) @(posedge clk);
        #1;
        run(16'hC3A5, -1, 16'h0);

        repeat (3) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mlp_infer_ctrl.md
Name: mlp_infer_ctrl

Overview:
- Sequences one inference of the 4x4 O/X classifier MLP (16 binary inputs, N_HID hidden neurons, 2 output neurons) over a single shared multiply-accumulate path and an external weight ROM.
- Sits between input_manager (which supplies the submitted 16-bit flag pattern and a start strobe) and the display/LCD logic (which consumes the class result).
- Owns ROM addressing, accumulation, ReLU clipping, hidden-activation storage and the final class decision.

Parameters:
- N_IN, 16, number of binary inputs (pattern width).
- N_HID, 8, number of hidden neurons.
- OUT_BASE, 136, ROM address of the first output-layer word; equals N_HID*(N_IN+1).

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin inference; sampled only in IDLE.
- pattern  in  16  input flags; latched on accepted start.
- rom_en  out  1  ROM read enable.
- rom_addr  out  8  ROM word address, registered.
- rom_data  in  8  signed weight/bias; valid exactly 1 cycle after rom_en.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  1-cycle pulse when the result is updated.
- result  out  2  01 = O, 10 = X, 00 = none.
- score_o  out  20  signed output-neuron-0 sum.
- score_x  out  20  signed output-neuron-1 sum.

Behaviour:
- Reset (synchronous, rst=1 at clk edge): state IDLE; busy=0, done=0, rom_en=0, rom_addr=0, result=00, score_o=0, score_x=0; hidden store cleared. Reset mid-inference aborts immediately; no done pulse follows.
- ROM layout:
  - Hidden neuron h, input i at h*(N_IN+1)+i; bias at h*(N_IN+1)+N_IN.
  - Output neuron k (0=O, 1=X), hidden j at OUT_BASE+k*(N_HID+1)+j; bias at OUT_BASE+k*(N_HID+1)+N_HID.
- State machine:
  - IDLE: on start=1, latch pattern, clear the 20-bit signed accumulator, go to HID. A start while not in IDLE is ignored, not queued.
  - HID: per neuron, N_IN+1 consecutive reads (inputs 0..N_IN-1, then bias). Then 1 drain cycle consumes the last word and writes the activation to the hidden store.
    - Accumulate: acc += sext(rom_data) when pattern[i]=1; the bias word is always added.
    - Neuron cost: N_IN+2 cycles.
    - ReLU clip: acc<0 -> 0; acc>255 -> 255; else acc[7:0]. Store is 8-bit unsigned.
    - acc clears for the next neuron.
    - After neuron N_HID-1, go to OUT.
  - OUT: per output neuron, N_HID+1 reads plus 1 drain cycle, i.e. N_HID+2 cycles.
    - Accumulate: acc += signed(rom_data) * unsigned(hid[j]), 17-bit product sign-extended to 20 bits.
    - Bias: acc += sext(rom_data).
    - Drain writes score_o (k=0) or score_x (k=1).
  - DECIDE (1 cycle):
    - result=01 if score_o>0 and score_o>=score_x (tie -> O).
    - result=10 if score_x>0 and score_x>score_o.
    - Otherwise result=00.
    - done=1, busy=0, return to IDLE.
- Timing and hold:
  - rom_addr/rom_en issue one address per cycle with no gaps within a neuron; rom_en=0 during drain and DECIDE cycles.
  - Latency: done is high exactly N_HID*(N_IN+2)+2*(N_HID+2)+1 = 165 cycles after the start-sampling edge (defaults).
  - result and scores hold until the next DECIDE; they are not cleared on start.
- Width rule: a 20-bit signed accumulator cannot overflow with 8-bit weights at defaults; no saturation is applied to scores.
- start held high continuously: a new inference begins in the cycle after done (IDLE re-samples start).

Test Plan:
- All ROM words 0, pattern=16'hF99F, start pulse -> done exactly 165 cycles later; score_o=score_x=0; result=00; busy high for cycles 1..164.
- ROM with hidden 0 weights +10 on ring bits of 16'hF99F (others -10), bias 0; output-O weight j0=+1; others 0 -> hid0=120, score_o=120, score_x=0, result=01.
- Hidden 0: all weights +127, bias +127, pattern=16'hFFFF -> acc=2159 clipped to hid0=255. Output-X weight j0=+127 -> score_x=32385, result=10.
- Tie: score_o=score_x=50 via biases only -> result=01; both biases -5 -> result=00.
- start re-pulsed at cycle 40 of a run with a different pattern -> ignored; done still at cycle 165 with the original pattern's result.
- rst=1 at cycle 80 -> next edge: busy=0, rom_en=0, result=00, scores 0; no done pulse. A fresh start then completes normally in 165 cycles.
